// File: rtl/up_to_limit_if.sv
// Control and BCD count bus for the up_to_limit elapsed-time counter.
`timescale 1ns/1ps
interface up_to_limit_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] limit_tens;
  logic [3:0] limit_units;
  logic [3:0] q_tens;
  logic [3:0] q_units;
  logic       running;
  logic       done;
  logic       done_pulse;
  logic       carry;

  modport master (
    output tick, start, stop, clear, limit_tens, limit_units,
    input  q_tens, q_units, running, done, done_pulse, carry
  );

  modport slave (
    input  tick, start, stop, clear, limit_tens, limit_units,
    output q_tens, q_units, running, done, done_pulse, carry
  );
endinterface

// File: rtl/up_to_limit.sv
// Two-digit BCD up-counter that runs on tick strobes until it reaches a
// latched target, with pause/resume and abort; every output is registered.
`timescale 1ns/1ps
module up_to_limit #(
  parameter int unsigned TENS_MAX = 5
) (
  input  logic          clock,
  input  logic          reset,
  up_to_limit_if.slave  bus
);

  localparam int unsigned DW = 4;
  localparam logic [DW-1:0] TMAX  = DW'(TENS_MAX);
  localparam logic [DW-1:0] NINE  = DW'(9);
  localparam logic [DW-1:0] ZERO  = DW'(0);
  localparam logic [DW-1:0] ONE   = DW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] tens_q, tens_d, units_q, units_d;
  logic [DW-1:0] lim_t_q, lim_t_d, lim_u_q, lim_u_d;
  logic          running_q, running_d, done_q, done_d;
  logic          dpulse_q, dpulse_d, carry_q, carry_d;

  logic [DW-1:0] in_t_c, in_u_c, inc_t_c, inc_u_c;
  logic          zero_lim_c, advance_c, hit_c, arm_c;

  // Clamped limit inputs and the incremented count candidate.
  always_comb begin
    in_u_c     = (bus.limit_units > NINE) ? NINE : bus.limit_units;
    in_t_c     = (bus.limit_tens  > TMAX) ? TMAX : bus.limit_tens;
    zero_lim_c = (in_t_c == ZERO) && (in_u_c == ZERO);
    if (units_q == NINE) begin
      inc_u_c = ZERO;
      inc_t_c = tens_q + ONE;
    end else begin
      inc_u_c = units_q + ONE;
      inc_t_c = tens_q;
    end
    arm_c     = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.start;
    advance_c = (state_q == S_RUN) && !bus.stop && bus.tick;
    hit_c     = (inc_t_c == lim_t_q) && (inc_u_c == lim_u_q);
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tens_q    <= ZERO;
      units_q   <= ZERO;
      lim_t_q   <= ZERO;
      lim_u_q   <= ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      dpulse_q  <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      units_q   <= units_d;
      lim_t_q   <= lim_t_d;
      lim_u_q   <= lim_u_d;
      running_q <= running_d;
      done_q    <= done_d;
      dpulse_q  <= dpulse_d;
      carry_q   <= carry_d;
    end
  end

  // Next state: clear beats start/stop, which beat tick.
  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (bus.start) state_d = zero_lim_c ? S_DONE : S_RUN;
        S_RUN: begin
          if (bus.stop)                state_d = S_PAUSE;
          else if (advance_c && hit_c) state_d = S_DONE;
        end
        S_PAUSE: if (bus.start) state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of count, latched limit and status outputs.
  always_comb begin
    tens_d    = tens_q;
    units_d   = units_q;
    lim_t_d   = lim_t_q;
    lim_u_d   = lim_u_q;
    carry_d   = 1'b0;
    dpulse_d  = 1'b0;
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    if (bus.clear) begin
      tens_d  = ZERO;
      units_d = ZERO;
    end else if (arm_c) begin
      tens_d   = ZERO;
      units_d  = ZERO;
      lim_t_d  = in_t_c;
      lim_u_d  = in_u_c;
      dpulse_d = zero_lim_c;
    end else if (advance_c) begin
      tens_d   = inc_t_c;
      units_d  = inc_u_c;
      carry_d  = (units_q == NINE);
      dpulse_d = hit_c;
    end
  end

  assign bus.q_tens     = tens_q;
  assign bus.q_units    = units_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = dpulse_q;
  assign bus.carry      = carry_q;

endmodule

// File: tb/tb_up_to_limit.sv
// Directed bench for up_to_limit: integer-count reference model checked every
// cycle, plus hand-computed checkpoints for the key scenarios.
`timescale 1ns/1ps
module tb_up_to_limit;
  localparam int TENS_MAX = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  up_to_limit_if bus();

  up_to_limit #(.TENS_MAX(TENS_MAX)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: elapsed count as a plain integer 0..99.
  int m_st  = M_IDLE;
  int m_n   = 0;
  int m_lim = 0;
  bit m_carry = 1'b0;
  bit m_dp    = 1'b0;

  logic [11:0] got_v, exp_v;

  task automatic model_step();
    int lt, lu;
    m_carry = 1'b0;
    m_dp    = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_n = 0; m_lim = 0;
    end else if (bus.clear) begin
      m_st = M_IDLE; m_n = 0;
    end else if ((m_st == M_IDLE || m_st == M_DONE) && bus.start) begin
      lt = (int'(bus.limit_tens) > TENS_MAX) ? TENS_MAX : int'(bus.limit_tens);
      lu = (int'(bus.limit_units) > 9) ? 9 : int'(bus.limit_units);
      m_lim = lt * 10 + lu;
      m_n = 0;
      if (m_lim == 0) begin m_st = M_DONE; m_dp = 1'b1; end
      else m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (bus.stop) m_st = M_PAUSE;
      else if (bus.tick) begin
        m_n = m_n + 1;
        m_carry = (m_n % 10 == 0);
        if (m_n == m_lim) begin m_st = M_DONE; m_dp = 1'b1; end
      end
    end else if (m_st == M_PAUSE && bus.start) begin
      m_st = M_RUN;
    end
  endtask

  task automatic compare();
    got_v = {bus.q_tens, bus.q_units, bus.running, bus.done, bus.done_pulse, bus.carry};
    exp_v = {4'(m_n / 10), 4'(m_n % 10), (m_st == M_RUN), (m_st == M_DONE), m_dp, m_carry};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL model_cycle t=%0t got=%h expected=%h", $time, got_v, exp_v);
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input bit t, input bit s, input bit p, input bit c);
    bus.tick = t; bus.start = s; bus.stop = p; bus.clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic set_lim(input int t, input int u);
    bus.limit_tens  = 4'(t);
    bus.limit_units = 4'(u);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int q_bcd();
    return int'({bus.q_tens, bus.q_units});
  endfunction

  function automatic int flags();
    return int'({bus.running, bus.done, bus.done_pulse, bus.carry});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
    set_lim(0, 0);
    fork
      forever begin
        @(negedge clk);
        if (chk_en) compare();
      end
    join_none

    @(negedge clk);
    rst = 1'b1; cyc(1'b0, 1'b1, 1'b0, 1'b0); rst = 1'b0;
    chk_en = 1'b1;
    lit("reset_count", q_bcd(), 'h00);
    lit("reset_flags", flags(), 0);

    // Limit 15: carry after tick 10, done on tick 15.
    set_lim(1, 5); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 9)  lit("no_carry_at_09", int'(bus.carry), 0);
      if (i == 10) lit("carry_at_10", int'(bus.carry), 1);
      if (i == 11) lit("carry_single_cycle", int'(bus.carry), 0);
    end
    lit("count_15", q_bcd(), 'h15);
    lit("flags_at_15", flags(), 4'b0110);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    lit("done_pulse_one_cycle", flags(), 4'b0100);

    // Limit 59: 70 ticks, extra ticks ignored once done.
    set_lim(5, 9); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(70);
    lit("count_59_held", q_bcd(), 'h59);
    lit("done_59", int'(bus.done), 1);

    // Limit 07 with a pause; limit change while paused is ignored.
    set_lim(0, 7); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    lit("paused_at_03", q_bcd(), 'h03);
    lit("paused_flags", flags(), 0);
    set_lim(0, 1);
    ticks(5);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    lit("still_03", q_bcd(), 'h03);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    lit("resumed_06_running", flags(), 4'b1000);
    ticks(1);
    lit("count_07", q_bcd(), 'h07);
    lit("done_07", int'(bus.done), 1);

    // Out-of-range limit clamps to 59; limit 00 finishes immediately.
    set_lim(15, 12); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(60);
    lit("clamped_59", q_bcd(), 'h59);
    set_lim(0, 0); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    lit("zero_limit_flags", flags(), 4'b0110);
    lit("zero_limit_count", q_bcd(), 'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    lit("zero_limit_pulse_drop", flags(), 4'b0100);

    // Clear with tick at 42, then a short run to 02.
    set_lim(5, 9); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(42);
    lit("count_42", q_bcd(), 'h42);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    lit("cleared_count", q_bcd(), 'h00);
    lit("cleared_flags", flags(), 0);
    set_lim(0, 2); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);
    lit("count_02_done", q_bcd(), 'h02);
    lit("flags_02", flags(), 4'b0110);

    // Reset with tick at 09: no carry, and idle ticks stay at 00.
    set_lim(5, 9); cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(9);
    lit("count_09", q_bcd(), 'h09);
    rst = 1'b1; cyc(1'b1, 1'b0, 1'b0, 1'b0); rst = 1'b0;
    lit("reset_mid_count", q_bcd(), 'h00);
    lit("reset_mid_flags", flags(), 0);
    ticks(3);
    lit("idle_ticks_ignored", q_bcd(), 'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/up_to_limit.md
UP_TO_LIMIT -- requirements
Module: up_to_limit

Interface
REQ-001 Parameter TENS_MAX, default 5, highest legal tens digit; count range is 00..(TENS_MAX)9.
REQ-002 clock  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-cycle count-enable pulse (1 Hz strobe from prescaler).
REQ-005 start  input  1  begin count from 00, or resume from pause.
REQ-006 stop  input  1  pause counting.
REQ-007 clear  input  1  abort and return to idle.
REQ-008 limit_tens  input  4  BCD tens digit of target.
REQ-009 limit_units  input  4  BCD units digit of target.
REQ-010 q_tens  output  4  BCD tens of elapsed count.
REQ-011 q_units  output  4  BCD units of elapsed count.
REQ-012 running  output  1  high in RUNNING only.
REQ-013 done  output  1  high in DONE only.
REQ-014 done_pulse  output  1  one cycle high on entry to DONE.
REQ-015 carry  output  1  one cycle high when units wraps 9->0.

Function
REQ-016 States: IDLE, RUNNING, PAUSED, DONE; all outputs registered.
REQ-017 Input priority each edge: reset > clear > start/stop > tick.
REQ-018 IDLE: start -> RUNNING, count := 00, limit latched; tick ignored.
REQ-019 Latched limit: units > 9 clamps to 9; tens > TENS_MAX clamps to TENS_MAX.
REQ-020 Latched limit 00: IDLE + start -> DONE directly, done_pulse on that edge, count 00.
REQ-021 RUNNING, tick, no stop: units 0..8 increments; units 9 -> units 0, tens +1, carry high next cycle.
REQ-022 Count update and DONE entry occur on the same edge: if incremented count equals latched limit, state -> DONE, count holds that value.
REQ-023 Count never exceeds latched limit; no wrap past (TENS_MAX)9.
REQ-024 RUNNING + stop -> PAUSED, count frozen; stop with tick on same edge: tick dropped.
REQ-025 PAUSED + start -> RUNNING, count and latched limit retained; limit inputs not relatched.
REQ-026 start and stop on same edge: stop wins in RUNNING, start wins in IDLE/PAUSED/DONE.
REQ-027 DONE: count held, tick ignored; start behaves as in IDLE (count 00, relatch, RUNNING).
REQ-028 clear in any state -> IDLE, count 00, carry and done_pulse low next cycle.
REQ-029 stop in IDLE, PAUSED, DONE has no effect.
REQ-030 Limit inputs changed while RUNNING/PAUSED have no effect until next start from IDLE/DONE.
REQ-031 q_tens, q_units always valid BCD; carry and done_pulse never high more than one consecutive cycle.

Reset
REQ-032 On reset edge: state IDLE, q_tens=0, q_units=0, latched limit 00, running=0, done=0, done_pulse=0, carry=0.
REQ-033 reset mid-count overrides all other inputs on the same edge; no carry or done_pulse emitted.

Verification
REQ-034 reset; limit 1/5; start; 15 ticks -> count 01..15, carry after tick 10, done and done_pulse on tick 15, running low.
REQ-035 limit 5/9 (TENS_MAX 5); start; 70 ticks -> stops at 59, done high, ticks 60-70 ignored, count held 59.
REQ-036 limit 0/7; start; 3 ticks; stop with simultaneous tick -> 03 held; 5 ticks -> 03; start; 4 ticks -> 07, done.
REQ-037 limit F/C -> clamped to 5/9; limit 0/0 + start -> DONE next edge, done_pulse one cycle, count 00.
REQ-038 RUNNING at 42: clear and tick same edge -> IDLE, 00; start with limit changed to 0/2 -> done after 2 ticks.
REQ-039 RUNNING at 09: reset with tick -> all outputs 0, no carry pulse; ticks in IDLE leave count 00.
